fu_cdb_arbiter: RTL and testbench
=================================

# fu_cdb_arbiter

Completion scheduler between the functional units and the common data bus. Each cycle it picks up to `N_CDB` of the ALU, multiplier and load units that report a prepared result and returns per-unit `avail` grants. It uses a rotating priority, so no unit starves. Granted results are registered onto the CDB outputs, and completion notices go to the ROB one cycle later. It is the "priority selector" that drives the `alu_avail`, `mult_avail` and `load_avail` inputs of `fu`.

## Interface
Parameters:
- `N_ALU`, default `NUM_FU_ALU`: number of ALU requesters.
- `N_MULT`, default `NUM_FU_MULT`: number of multiplier requesters.
- `N_LOAD`, default `NUM_FU_LOAD`: number of load requesters.
- `N_CDB`, default `NUM_CDB`: CDB broadcast slots per cycle, 1..N_REQ.
- `N_REQ`, derived as `N_ALU+N_MULT+N_LOAD`: flat requester count, at most 16.

Ports:
- `clock`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low. All state clears while it is 0.
- `squash`, input, 1: synchronous flush on branch mispredict.
- `fu_state_packet`, input, `FU_STATE_PACKET`: prepared bits and result packets from `fu`.
- `alu_avail`, output, `N_ALU`: combinational grant per ALU.
- `mult_avail`, output, `N_MULT`: combinational grant per multiplier.
- `load_avail`, output, `N_LOAD`: combinational grant per load unit.
- `cdb_valid`, output, `N_CDB`: registered slot-valid bits.
- `cdb_packet`, output, `CDB_PACKET [N_CDB]`: registered `{dest_prn, value}`.
- `cdb_robn`, output, `ROBN [N_CDB]`: registered ROB index per slot, used to mark the entry complete.
- `grant_count`, output, `$clog2(N_CDB+1)`: number of grants this cycle, combinational. Feeds the RS issue throttle.

## Operation
- Flat request vector `req`, in index order: ALU0..ALU(N_ALU-1), then MULT0.., then LOAD0.. Bit i is the corresponding prepared bit.
- Rotating pointer `ptr`, `$clog2(N_REQ)` bits. The search starts at `ptr` and wraps modulo N_REQ.
  - Slot 0 takes the first set `req` bit at or after `ptr`.
  - Slot k takes the next set bit after slot k-1, masking bits already granted.
  - Slots with no remaining request are invalid.
- `grant` is the OR of the slot one-hots. The flat vector is split back into `alu_avail`, `mult_avail` and `load_avail`. `avail` is never asserted for a unit whose prepared bit is 0.
- A requester not granted holds its packet and keeps prepared high. The multiplier stalls internally on `avail`=0, and the RS does not reissue onto an ungranted ALU.
- Pointer update:
  - If any grant, `ptr` becomes (index of the last valid slot + 1) mod N_REQ.
  - Otherwise `ptr` holds.
- Output register, per slot k:
  - `cdb_valid[k]` is the slot-valid bit.
  - `cdb_packet[k]` is `{dest_prn, result}`.
  - `cdb_robn[k]` is `robn` from the winning unit's basic packet. For ALUs this is `.basic`.
- `squash`=1 forces the following:
  - All `avail`=0 and `grant_count`=0 in that cycle.
  - The next `cdb_valid` is all 0.
  - `ptr` resets to 0.
- Fairness: any continuously prepared requester is granted within ceil(N_REQ/N_CDB) cycles, absent squash.

## Timing
- Grant latency is 0 cycles, combinational from `fu_state_packet.*_prepared` to `*_avail`.
- CDB latency is 1 cycle: a grant in cycle t appears on `cdb_*` in cycle t+1 and lasts exactly one cycle.
- Reset (`reset`=0, asynchronous): `ptr`=0, `cdb_valid`=0, `cdb_packet`=0, `cdb_robn`=0. Grants are forced to 0 while reset is low.
- Reset deasserted mid-operation: the first cycle after release arbitrates from `ptr`=0. No in-flight CDB slot survives.
- No requests: all outputs invalid and `ptr` holds.
- Requests fewer than N_CDB: all are granted, and the upper slots are invalid.
- Requests greater than N_CDB: exactly N_CDB are granted.
- Pointer wrap: when the last grant is at index N_REQ-1, `ptr` goes to 0.
- `squash` and `reset` together: reset dominates.
- `squash` and a request in the same cycle: squash wins and nothing is granted.

## Structure
- The following belong in `sys_defs.svh`:
  - `CDB_PACKET` and `FU_STATE_PACKET`, already present.
  - A new macro `NUM_CDB`, default 2.
- Sub-module `rr_pick`: a combinational one-hot picker with inputs `req` and `start` and outputs `gnt` and `idx`. It is instantiated N_CDB times in a chain, with the prior grants masked out of `req`.
- The top level holds `ptr`, the output registers and the split/merge of the flat vector.

## Test plan
All scenarios use N_ALU=3, N_MULT=2, N_LOAD=1, N_CDB=2.
- Reset: hold `reset`=0 with all prepared set. Required: all `avail`=0 and `cdb_valid`=00. After release, the first cycle grants ALU0 and ALU1, and `ptr`=2.
- Single request: only MULT1 (flat 4) prepared, `dest_prn`=7, result `32'h1234`. Required: `mult_avail`=10 and `grant_count`=1. Next cycle, `cdb_valid`=01 with `{7, 32'h1234}`, and `ptr`=5.
- Wrap: `ptr`=5 with LOAD0 and ALU0 prepared. Required: slot0=LOAD0, slot1=ALU0, and next `ptr`=1.
- Saturation: all 6 prepared for 3 cycles. Required grants are {0,1}, then {2,3}, then {4,5}, with `ptr` returning to 0.
- Starvation: MULT0 held prepared while ALU0..2 are refilled every cycle. Required: MULT0 is granted within 3 cycles.
- Squash: squash=1 with 4 requests. Required: `avail`=0, next `cdb_valid`=00 and `ptr`=0. Unserved units still show prepared next cycle and are granted then.

Source files
------------

// File: rtl/fu_cdb_arbiter_pkg.sv
// Shared types and sizing for the functional-unit to CDB completion arbiter.
package fu_cdb_arbiter_pkg;

  localparam int NUM_FU_ALU  = 3;
  localparam int NUM_FU_MULT = 2;
  localparam int NUM_FU_LOAD = 1;
  localparam int NUM_CDB     = 2;

  localparam int XLEN  = 32;
  localparam int PRN_W = 6;
  localparam int ROB_W = 5;

  typedef logic [PRN_W-1:0] PRN;
  typedef logic [XLEN-1:0]  DATA;
  typedef logic [ROB_W-1:0] ROBN;

  // What travels on one CDB slot.
  typedef struct packed {
    PRN  dest_prn;
    DATA value;
  } CDB_PACKET;

  // Common completion record carried by every functional unit.
  typedef struct packed {
    ROBN robn;
    PRN  dest_prn;
    DATA result;
  } BASIC_PACKET;

  // ALU results wrap the common record in a .basic field.
  typedef struct packed {
    BASIC_PACKET basic;
  } ALU_PACKET;

  // Prepared bits plus result packets as reported by the functional units.
  typedef struct packed {
    logic [NUM_FU_ALU-1:0]         alu_prepared;
    ALU_PACKET [NUM_FU_ALU-1:0]    alu_packet;
    logic [NUM_FU_MULT-1:0]        mult_prepared;
    BASIC_PACKET [NUM_FU_MULT-1:0] mult_packet;
    logic [NUM_FU_LOAD-1:0]        load_prepared;
    BASIC_PACKET [NUM_FU_LOAD-1:0] load_packet;
  } FU_STATE_PACKET;

endpackage

// File: rtl/fu_cdb_arbiter_rr_pick.sv
// Combinational one-hot picker: first set request at or after start, wrapping.
module fu_cdb_arbiter_rr_pick #(
  parameter int N  = 6,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // Scan N positions from start, taking the first requester encountered.
  always_comb begin
    int          pos;
    logic [IW-1:0] pos_idx;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int off = 0; off < N; off++) begin
      pos = int'(start) + off;
      if (pos >= N) begin
        pos = pos - N;
      end
      pos_idx = IW'(pos);
      if (!valid && req[pos_idx]) begin
        valid        = 1'b1;
        gnt[pos_idx] = 1'b1;
        idx          = pos_idx;
      end
    end
  end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// Rotating-priority completion arbiter: grants up to N_CDB prepared units per
// cycle and registers the winners onto the common data bus.
module fu_cdb_arbiter
  import fu_cdb_arbiter_pkg::*;
#(
  parameter int N_ALU  = NUM_FU_ALU,
  parameter int N_MULT = NUM_FU_MULT,
  parameter int N_LOAD = NUM_FU_LOAD,
  parameter int N_CDB  = NUM_CDB
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         squash,
  input  FU_STATE_PACKET               fu_state_packet,
  output logic [N_ALU-1:0]             alu_avail,
  output logic [N_MULT-1:0]            mult_avail,
  output logic [N_LOAD-1:0]            load_avail,
  output logic [N_CDB-1:0]             cdb_valid,
  output CDB_PACKET                    cdb_packet [N_CDB],
  output ROBN                          cdb_robn [N_CDB],
  output logic [$clog2(N_CDB+1)-1:0]   grant_count
);

  localparam int N_REQ = N_ALU + N_MULT + N_LOAD;
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = $clog2(N_CDB + 1);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] grant;
  BASIC_PACKET      flat_pkt [N_REQ];

  logic [N_REQ-1:0] mask     [N_CDB];
  logic [N_REQ-1:0] slot_gnt [N_CDB];
  logic [IW-1:0]    slot_idx [N_CDB];
  logic [N_CDB-1:0] slot_valid;

  logic [IW-1:0]    ptr_reg;
  logic [IW-1:0]    ptr_next;

  // Flatten units into one request vector: ALUs, then multipliers, then loads.
  genvar gi;
  generate
    for (gi = 0; gi < N_ALU; gi++) begin : g_alu
      assign req[gi]      = fu_state_packet.alu_prepared[gi];
      assign flat_pkt[gi] = fu_state_packet.alu_packet[gi].basic;
    end
    for (gi = 0; gi < N_MULT; gi++) begin : g_mult
      assign req[N_ALU+gi]      = fu_state_packet.mult_prepared[gi];
      assign flat_pkt[N_ALU+gi] = fu_state_packet.mult_packet[gi];
    end
    for (gi = 0; gi < N_LOAD; gi++) begin : g_load
      assign req[N_ALU+N_MULT+gi]      = fu_state_packet.load_prepared[gi];
      assign flat_pkt[N_ALU+N_MULT+gi] = fu_state_packet.load_packet[gi];
    end
  endgenerate

  // Nothing may be granted during reset or on a flush cycle.
  assign req_eff = (reset && !squash) ? req : '0;
  assign mask[0] = req_eff;

  // Chain of pickers; each slot sees the requests left after earlier slots.
  generate
    for (gi = 0; gi < N_CDB; gi++) begin : g_slot
      fu_cdb_arbiter_rr_pick #(
        .N  (N_REQ),
        .IW (IW)
      ) u_pick (
        .req   (mask[gi]),
        .start (ptr_reg),
        .gnt   (slot_gnt[gi]),
        .idx   (slot_idx[gi]),
        .valid (slot_valid[gi])
      );
      if (gi < N_CDB - 1) begin : g_mask
        assign mask[gi+1] = mask[gi] & ~slot_gnt[gi];
      end
    end
  endgenerate

  // Merge slot one-hots into the flat grant and count the filled slots.
  always_comb begin
    grant       = '0;
    grant_count = '0;
    for (int k = 0; k < N_CDB; k++) begin
      grant       = grant | slot_gnt[k];
      grant_count = grant_count + CW'(slot_valid[k]);
    end
  end

  assign alu_avail  = grant[N_ALU-1:0];
  assign mult_avail = grant[N_ALU +: N_MULT];
  assign load_avail = grant[N_ALU+N_MULT +: N_LOAD];

  // Advance the pointer past the last granted requester; flush restarts at 0.
  always_comb begin
    ptr_next = ptr_reg;
    if (squash) begin
      ptr_next = '0;
    end else begin
      for (int k = 0; k < N_CDB; k++) begin
        if (slot_valid[k]) begin
          ptr_next = (slot_idx[k] == IW'(N_REQ - 1)) ? '0 : slot_idx[k] + IW'(1);
        end
      end
    end
  end

  // Register pointer and CDB slots; invalid slots carry zeros.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_reg   <= '0;
      cdb_valid <= '0;
      for (int k = 0; k < N_CDB; k++) begin
        cdb_packet[k] <= '0;
        cdb_robn[k]   <= '0;
      end
    end else begin
      ptr_reg   <= ptr_next;
      cdb_valid <= slot_valid;
      for (int k = 0; k < N_CDB; k++) begin
        if (slot_valid[k]) begin
          cdb_packet[k] <= {flat_pkt[slot_idx[k]].dest_prn, flat_pkt[slot_idx[k]].result};
          cdb_robn[k]   <= flat_pkt[slot_idx[k]].robn;
        end else begin
          cdb_packet[k] <= '0;
          cdb_robn[k]   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// Bench for fu_cdb_arbiter with 3 ALU, 2 MULT, 1 LOAD units and 2 CDB slots.
module tb_fu_cdb_arbiter;
  import fu_cdb_arbiter_pkg::*;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           squash = 1'b0;
  FU_STATE_PACKET fsp;
  logic [2:0]     alu_avail;
  logic [1:0]     mult_avail;
  logic [0:0]     load_avail;
  logic [1:0]     cdb_valid;
  CDB_PACKET      cdb_packet [2];
  ROBN            cdb_robn [2];
  logic [1:0]     grant_count;

  int checks = 0;
  int errors = 0;

  // Reference state: pointer, picked requester indices, per-unit packets.
  int          mptr = 0;
  int          exp_idx [2];
  int          exp_n;
  BASIC_PACKET unit_pkt [6];

  typedef struct {
    logic [5:0] req;
    logic       sq;
    logic [5:0] grant;
    int         cnt;
  } vec_t;
  vec_t tbl [13];

  always #5 clock = ~clock;

  fu_cdb_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .squash          (squash),
    .fu_state_packet (fsp),
    .alu_avail       (alu_avail),
    .mult_avail      (mult_avail),
    .load_avail      (load_avail),
    .cdb_valid       (cdb_valid),
    .cdb_packet      (cdb_packet),
    .cdb_robn        (cdb_robn),
    .grant_count     (grant_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] r);
    for (int i = 0; i < 6; i++) begin
      unit_pkt[i].robn     = ROBN'($urandom);
      unit_pkt[i].dest_prn = PRN'($urandom);
      unit_pkt[i].result   = $urandom;
    end
    if (r == 6'b010000) begin
      unit_pkt[4].dest_prn = 6'd7;
      unit_pkt[4].result   = 32'h1234;
    end
    fsp.alu_prepared  = r[2:0];
    fsp.mult_prepared = r[4:3];
    fsp.load_prepared = r[5:5];
    for (int i = 0; i < 3; i++) fsp.alu_packet[i].basic = unit_pkt[i];
    for (int i = 0; i < 2; i++) fsp.mult_packet[i] = unit_pkt[3+i];
    fsp.load_packet[0] = unit_pkt[5];
  endtask

  // Walk the ring from the pointer, taking the first two requesters seen.
  task automatic model(input logic [5:0] r, input logic sq);
    int pos;
    exp_n = 0;
    if (!sq) begin
      for (int off = 0; off < 6; off++) begin
        pos = (mptr + off) % 6;
        if (r[pos] && exp_n < 2) begin
          exp_idx[exp_n] = pos;
          exp_n++;
        end
      end
    end
  endtask

  // One arbitration cycle: check grants mid-cycle, CDB slots after the edge.
  task automatic run_cycle(input string tag, input logic [5:0] r, input logic sq,
                           output logic [5:0] g, output int n);
    logic [5:0] eg;
    logic [1:0] ev;
    drive(r);
    squash = sq;
    model(r, sq);
    eg = '0;
    for (int k = 0; k < exp_n; k++) eg[exp_idx[k]] = 1'b1;
    @(negedge clock);
    g = {load_avail, mult_avail, alu_avail};
    n = int'(grant_count);
    chk({tag, ".grant"}, 64'(g), 64'(eg));
    chk({tag, ".count"}, 64'(n), 64'(exp_n));
    @(posedge clock);
    #1;
    ev = (exp_n == 2) ? 2'b11 : (exp_n == 1) ? 2'b01 : 2'b00;
    chk({tag, ".cdb_valid"}, 64'(cdb_valid), 64'(ev));
    for (int k = 0; k < exp_n; k++) begin
      chk({tag, ".cdb_packet"}, 64'(cdb_packet[k]),
          64'({unit_pkt[exp_idx[k]].dest_prn, unit_pkt[exp_idx[k]].result}));
      chk({tag, ".cdb_robn"}, 64'(cdb_robn[k]), 64'(unit_pkt[exp_idx[k]].robn));
    end
    if (r == 6'b010000 && !sq) begin
      chk({tag, ".single_pkt"}, 64'(cdb_packet[0]), 64'({6'd7, 32'h1234}));
    end
    if (sq) mptr = 0;
    else if (exp_n > 0) mptr = (exp_idx[exp_n-1] + 1) % 6;
    squash = 1'b0;
    $display("%s req=%b sq=%b grant=%b cnt=%0d cdb_valid=%b ptr=%0d",
             tag, r, sq, g, n, cdb_valid, mptr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] g;
    int         n;
    int         got;

    // Expected grants derived by hand from ptr=0 after reset release.
    tbl[0]  = '{6'b111111, 1'b0, 6'b000011, 2}; // ptr -> 2
    tbl[1]  = '{6'b111111, 1'b0, 6'b001100, 2}; // ptr -> 4
    tbl[2]  = '{6'b111111, 1'b0, 6'b110000, 2}; // ptr -> 0
    tbl[3]  = '{6'b010000, 1'b0, 6'b010000, 1}; // MULT1 only, ptr -> 5
    tbl[4]  = '{6'b100001, 1'b0, 6'b100001, 2}; // wrap, ptr -> 1
    tbl[5]  = '{6'b000000, 1'b0, 6'b000000, 0}; // idle, ptr holds 1
    tbl[6]  = '{6'b000001, 1'b0, 6'b000001, 1}; // ptr -> 1
    tbl[7]  = '{6'b011110, 1'b1, 6'b000000, 0}; // squash, ptr -> 0
    tbl[8]  = '{6'b011110, 1'b0, 6'b000110, 2}; // ptr -> 3
    tbl[9]  = '{6'b011000, 1'b0, 6'b011000, 2}; // ptr -> 5
    tbl[10] = '{6'b000111, 1'b0, 6'b000011, 2}; // ptr -> 2
    tbl[11] = '{6'b100100, 1'b0, 6'b100100, 2}; // last at 5, ptr -> 0
    tbl[12] = '{6'b000010, 1'b0, 6'b000010, 1}; // ptr -> 2

    fsp = '0;
    reset = 1'b0;
    drive(6'b111111);
    @(negedge clock);
    chk("reset.avail", 64'({load_avail, mult_avail, alu_avail}), 64'(0));
    chk("reset.count", 64'(grant_count), 64'(0));
    chk("reset.cdb_valid", 64'(cdb_valid), 64'(0));
    @(posedge clock);
    #1;
    chk("reset.cdb_valid_hold", 64'(cdb_valid), 64'(0));
    chk("reset.cdb_packet", 64'(cdb_packet[0]), 64'(0));
    reset = 1'b1;
    mptr = 0;

    for (int i = 0; i < 13; i++) begin
      run_cycle($sformatf("tbl%0d", i), tbl[i].req, tbl[i].sq, g, n);
      chk($sformatf("tbl%0d.table_grant", i), 64'(g), 64'(tbl[i].grant));
      chk($sformatf("tbl%0d.table_count", i), 64'(n), 64'(tbl[i].cnt));
    end

    // MULT0 stays prepared while the ALUs keep refilling.
    got = 0;
    for (int c = 0; c < 3 && got == 0; c++) begin
      run_cycle("starve", 6'b001111, 1'b0, g, n);
      if (g[3]) got = 1;
    end
    chk("starve.mult0_granted", 64'(got), 64'(1));

    // Random traffic with occasional squash.
    for (int i = 0; i < 200; i++) begin
      run_cycle("rand", 6'($urandom), ($urandom_range(0, 9) == 0), g, n);
    end

    // Asynchronous reset mid-operation wipes in-flight slots.
    run_cycle("pre_rst", 6'b111111, 1'b0, g, n);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst.cdb_valid", 64'(cdb_valid), 64'(0));
    chk("midrst.avail", 64'({load_avail, mult_avail, alu_avail}), 64'(0));
    chk("midrst.count", 64'(grant_count), 64'(0));
    mptr = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    run_cycle("rst_rel", 6'b111111, 1'b0, g, n);
    chk("rst_rel.from_zero", 64'(g), 64'(6'b000011));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
